seed_storage_bank: RTL and testbench
====================================

Name: seed_storage_bank

Overview:
- Parametrised multi-slot seed store for the FrodoKEM datapath. Holds SLOTS independent seeds, each WORDS×64 bits (e.g. seedA, seedSE, salt).
- Seeds are written word-by-word over a 64-bit deserialising input stream and read back word-by-word over a 64-bit serialising output stream, using the isReady/canReceive/isLast handshake.
- Adds per-command slot selection, a single-cycle zeroize op, and a destructive read (read-and-wipe) for one-shot seeds.

Parameters:
- WORDS, 2, 64-bit words per seed (≥1).
- SLOTS, 4, number of seed slots (≥1, need not be a power of two).
- SLOT_W, max(1,$clog2(SLOTS)), slot index width (derived, localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high; resets control only, never seed data.
- cmd  in  SLOT_W+2  {slot[SLOT_W-1:0], op[1:0]}; op: 00 WRITE, 01 READ, 10 ZERO, 11 READ_WIPE.
- cmd_isReady  in  1  cmd valid.
- cmd_canReceive  out  1  block idle, cmd accepted this cycle if cmd_isReady.
- in  in  64  deserialiser data word.
- in_isReady  in  1  input word valid.
- in_canReceive  out  1  block accepts an input word.
- in_isLast  out  1  the currently expected input word is the last of the seed.
- out  out  64  serialiser data word.
- out_isReady  out  1  output word valid.
- out_canReceive  in  1  consumer accepts the output word.
- out_isLast  out  1  the current output word is the last of the seed.
- err_badSlot  out  1  one-cycle pulse: command named slot ≥ SLOTS.

Behaviour:
- Storage: SLOTS×WORDS×64 flops with no reset; only WRITE/ZERO/READ_WIPE modify them. Word k of a slot holds bits [64k+63:64k]. Word 0 is transferred first.
- Reset values: state IDLE, word counter 0; cmd_canReceive=1. in_canReceive, in_isLast, out_isReady, out_isLast and err_badSlot are 0. out is a don't-care when out_isReady=0 but must not be X-propagating control.
- FSM states: IDLE, IN, OUT, CLR.
- IDLE: cmd_canReceive=1. On cmd_isReady at cycle t, latch slot/op, counter←0, then:
  - slot≥SLOTS: err_badSlot=1 at t+1, stay IDLE, no storage change.
  - WRITE → IN; READ or READ_WIPE → OUT; ZERO → CLR.
- IN: in_canReceive=1 from t+1. On each in_isReady, store `in` into word[counter] and increment counter. in_isLast = (counter==WORDS-1). The beat with in_isLast returns to IDLE on the next cycle.
- OUT: out_isReady=1 from t+1, out = slot word[counter], out_isLast = (counter==WORDS-1). Data is held stable while out_canReceive=0. On each beat (out_isReady & out_canReceive), increment counter; for READ_WIPE, also write zero to that word in the same cycle. The last beat returns to IDLE.
- CLR: one cycle, all words of the slot ←0, then IDLE. ZERO latency is 2 cycles from acceptance to next cmd_canReceive.
- cmd_canReceive is 0 in IN/OUT/CLR. A new command is accepted at the earliest one cycle after the last beat.
- Only one of in_canReceive/out_isReady can be high at a time. In IN, out_isReady=0 regardless of out_canReceive. In OUT, in_canReceive=0 and in_isReady is ignored.
- WORDS=1: the first beat is also the last, so in_isLast/out_isLast are 1 throughout IN/OUT.
- Counter width is max(1,$clog2(WORDS)). The counter never wraps; the FSM leaves before overflow.
- Reset mid-operation: the FSM returns to IDLE immediately. Words already written or wiped keep their new value; remaining words are unchanged. No partial rollback.

Decomposition:
- Shared package seed_storage_pkg:
  - op encodings OP_WRITE=2'b00, OP_READ=2'b01, OP_ZERO=2'b10, OP_READ_WIPE=2'b11;
  - FSM state encodings;
  - `SeedStorageBankCMD_SIZE macro (SLOT_W+2).
- One natural sub-module, seed_word_sequencer: counter plus isLast generation, shared by the IN and OUT paths. Storage and the FSM stay in seed_storage_bank.

Test Plan:
- WRITE slot 2 with words 0x1111…1111 then 0x2222…2222, then READ slot 2 → out gives the same two words in order; out_isLast=1 only on the second; in_isLast=1 only on the second input beat.
- READ slot 1 with out_canReceive toggling 0/1 every cycle → `out` stable while stalled; exactly 2 beats; cmd_canReceive returns 1 one cycle after the last beat.
- READ_WIPE slot 2 (holding the previous values), then READ slot 2 → first read returns 0x1111…/0x2222…; second returns 0x0…0, 0x0…0.
- ZERO slot 0 after writing 0xDEADBEEF_00000001 ×2 → cmd_canReceive low exactly 1 cycle; a subsequent READ returns zeros; slots 1–3 unchanged.
- cmd slot=5 with SLOTS=5 (SLOT_W=3) → err_badSlot=1 for one cycle; no beats; all slots unchanged.
- Assert rst after the first WRITE beat to slot 3 (old contents A,B; new word0=C) → after reset, IDLE with cmd_canReceive=1; READ slot 3 returns C, B.

Source files
------------

// File: rtl/seed_storage_pkg.sv
// Shared encodings for the FrodoKEM seed store: command ops, FSM states,
// and the derived command width.
`ifndef SEED_STORAGE_PKG_SV
`define SEED_STORAGE_PKG_SV
`define SeedStorageBankCMD_SIZE (SLOT_W + 2)

package seed_storage_pkg;
  typedef enum logic [1:0] {
    OP_WRITE     = 2'b00,
    OP_READ      = 2'b01,
    OP_ZERO      = 2'b10,
    OP_READ_WIPE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_IN   = 2'b01,
    ST_OUT  = 2'b10,
    ST_CLR  = 2'b11
  } state_e;

  function automatic int clogMin1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage
`endif

// File: rtl/seed_word_sequencer.sv
// Word counter shared by the deserialising and serialising paths; it parks
// on the last word instead of wrapping.
module seed_word_sequencer
  import seed_storage_pkg::*;
#(
  parameter int WORDS = 2,
  localparam int CNT_W = clogMin1(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             isLast
);
  assign isLast = (cnt == CNT_W'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clear)           cnt <= '0;
    else if (step && !isLast) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/seed_storage_bank.sv
// Multi-slot seed store: word-serial write/read with slot select, one-cycle
// zeroize and read-and-wipe. Reset touches control state only.
module seed_storage_bank
  import seed_storage_pkg::*;
#(
  parameter int WORDS = 2,
  parameter int SLOTS = 4,
  localparam int SLOT_W = clogMin1(SLOTS),
  localparam int CNT_W  = clogMin1(WORDS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [`SeedStorageBankCMD_SIZE-1:0] cmd,
  input  logic                                 cmd_isReady,
  output logic                                 cmd_canReceive,
  input  logic [63:0]                          in,
  input  logic                                 in_isReady,
  output logic                                 in_canReceive,
  output logic                                 in_isLast,
  output logic [63:0]                          out,
  output logic                                 out_isReady,
  input  logic                                 out_canReceive,
  output logic                                 out_isLast,
  output logic                                 err_badSlot
);
  state_e             state, nxt;
  logic [SLOT_W-1:0]  slotQ;
  logic               wipeQ;
  logic [CNT_W-1:0]   cnt;
  logic               isLast;
  logic [SLOT_W-1:0]  cmdSlot;
  logic [1:0]         cmdOp;
  logic               accept, badSlot, inBeat, outBeat;
  logic [SLOTS-1:0][WORDS-1:0][63:0] memQ;

  assign cmdSlot = cmd[SLOT_W+1:2];
  assign cmdOp   = cmd[1:0];
  assign accept  = cmd_canReceive & cmd_isReady;
  assign badSlot = (32'(cmdSlot) >= SLOTS);
  assign inBeat  = in_canReceive & in_isReady;
  assign outBeat = out_isReady & out_canReceive;

  seed_word_sequencer #(.WORDS(WORDS)) uSeq (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .step   (inBeat | outBeat),
    .cnt    (cnt),
    .isLast (isLast)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      slotQ       <= '0;
      wipeQ       <= 1'b0;
      err_badSlot <= 1'b0;
    end else begin
      state       <= nxt;
      err_badSlot <= accept & badSlot;
      if (accept) begin
        slotQ <= cmdSlot;
        wipeQ <= (cmdOp == OP_READ_WIPE);
      end
    end
  end

  always_comb begin
    nxt            = state;
    cmd_canReceive = 1'b0;
    in_canReceive  = 1'b0;
    in_isLast      = 1'b0;
    out_isReady    = 1'b0;
    out_isLast     = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_canReceive = 1'b1;
        if (cmd_isReady && !badSlot) begin
          case (cmdOp)
            OP_WRITE: nxt = ST_IN;
            OP_ZERO:  nxt = ST_CLR;
            default:  nxt = ST_OUT;
          endcase
        end
      end
      ST_IN: begin
        in_canReceive = 1'b1;
        in_isLast     = isLast;
        if (in_isReady && isLast) nxt = ST_IDLE;
      end
      ST_OUT: begin
        out_isReady = 1'b1;
        out_isLast  = isLast;
        if (out_canReceive && isLast) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Data flops carry no reset so a mid-operation reset leaves finished words intact.
  for (genvar s = 0; s < SLOTS; s++) begin : gSlot
    for (genvar w = 0; w < WORDS; w++) begin : gWord
      logic [63:0] q;
      logic        hit;
      assign hit = (slotQ == SLOT_W'(s));
      always_ff @(posedge clk) begin
        if (hit) begin
          if (inBeat && cnt == CNT_W'(w))
            q <= in;
          else if (state == ST_CLR || (outBeat && wipeQ && cnt == CNT_W'(w)))
            q <= '0;
        end
      end
      assign memQ[s][w] = q;
    end
  end

  // Gate with out_isReady so never-written flops cannot leak X downstream.
  always_comb begin
    out = '0;
    for (int s = 0; s < SLOTS; s++)
      for (int w = 0; w < WORDS; w++)
        if (out_isReady && slotQ == SLOT_W'(s) && cnt == CNT_W'(w))
          out = memQ[s][w];
  end
endmodule

// File: tb/tb_seed_storage_bank.sv
// Directed bench for seed_storage_bank (WORDS=2, SLOTS=5): table of seed
// transactions plus hand sequences for bad slot and reset mid-write.
module tb_seed_storage_bank;
  import seed_storage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  cmd = '0;
  logic        cmd_isReady = 1'b0;
  logic        cmd_canReceive;
  logic [63:0] inW = '0;
  logic        in_isReady = 1'b0;
  logic        in_canReceive, in_isLast;
  logic [63:0] outW;
  logic        out_isReady, out_isLast;
  logic        out_canReceive = 1'b1;
  logic        err_badSlot;

  int checks = 0;
  int errors = 0;

  seed_storage_bank #(.WORDS(2), .SLOTS(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmd),
    .cmd_isReady    (cmd_isReady),
    .cmd_canReceive (cmd_canReceive),
    .in             (inW),
    .in_isReady     (in_isReady),
    .in_canReceive  (in_canReceive),
    .in_isLast      (in_isLast),
    .out            (outW),
    .out_isReady    (out_isReady),
    .out_canReceive (out_canReceive),
    .out_isLast     (out_isLast),
    .err_badSlot    (err_badSlot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  slot;
    logic [1:0]  op;
    bit          toggle;
    logic [63:0] d0;
    logic [63:0] d1;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] s, input logic [1:0] op);
    int n = 0;
    while (!cmd_canReceive && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("cmd wait timeout", 1'b0, 1'b1);
    cmd = {s, op};
    cmd_isReady = 1'b1;
    @(posedge clk); #1;
    cmd_isReady = 1'b0;
  endtask

  task automatic writeSeed(input logic [2:0] s, input logic [63:0] w0, input logic [63:0] w1);
    issue(s, OP_WRITE);
    for (int k = 0; k < 2; k++) begin
      inW = (k == 0) ? w0 : w1;
      in_isReady = 1'b1;
      chk("in_canReceive", in_canReceive, 1'b1);
      chk("in_isLast", in_isLast, (k == 1));
      chk("no out during write", out_isReady, 1'b0);
      @(posedge clk); #1;
    end
    in_isReady = 1'b0;
    chk("cmd ready after write", cmd_canReceive, 1'b1);
  endtask

  task automatic readCheck(input logic [2:0] s, input logic [1:0] op, input bit toggle,
                           input logic [63:0] e0, input logic [63:0] e1);
    int beats = 0;
    logic [63:0] held = '0;
    bit stalled = 1'b0;
    issue(s, op);
    chk("no in during read", in_canReceive, 1'b0);
    for (int c = 0; c < 20 && beats < 2; c++) begin
      out_canReceive = toggle ? c[0] : 1'b1;
      if (out_isReady) begin
        if (stalled) chk("stall hold", outW, held);
        if (out_canReceive) begin
          chk(beats == 0 ? "out word0" : "out word1", outW, beats == 0 ? e0 : e1);
          chk("out_isLast", out_isLast, (beats == 1));
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = outW;
        end
      end
      @(posedge clk); #1;
    end
    out_canReceive = 1'b1;
    chk("read beats", beats, 2);
    chk("cmd ready after read", cmd_canReceive, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{3'd0, OP_WRITE,     1'b0, 64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001};
    tbl[1]  = '{3'd1, OP_WRITE,     1'b0, 64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210};
    tbl[2]  = '{3'd2, OP_WRITE,     1'b0, 64'h11111111_11111111, 64'h22222222_22222222};
    tbl[3]  = '{3'd3, OP_WRITE,     1'b0, 64'h33333333_33333333, 64'h44444444_44444444};
    tbl[4]  = '{3'd4, OP_WRITE,     1'b0, 64'h55555555_55555555, 64'h66666666_66666666};
    tbl[5]  = '{3'd2, OP_READ,      1'b0, 64'h11111111_11111111, 64'h22222222_22222222};
    tbl[6]  = '{3'd1, OP_READ,      1'b1, 64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210};
    tbl[7]  = '{3'd2, OP_READ_WIPE, 1'b0, 64'h11111111_11111111, 64'h22222222_22222222};
    tbl[8]  = '{3'd2, OP_READ,      1'b0, 64'h0,                 64'h0};
    tbl[9]  = '{3'd0, OP_ZERO,      1'b0, 64'h0,                 64'h0};
    tbl[10] = '{3'd0, OP_READ,      1'b0, 64'h0,                 64'h0};
    tbl[11] = '{3'd1, OP_READ,      1'b1, 64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210};
    tbl[12] = '{3'd3, OP_READ,      1'b0, 64'h33333333_33333333, 64'h44444444_44444444};
    tbl[13] = '{3'd4, OP_READ,      1'b0, 64'h55555555_55555555, 64'h66666666_66666666};

    // Reset state
    #2;
    chk("rst cmd_canReceive", cmd_canReceive, 1'b1);
    chk("rst in_canReceive", in_canReceive, 1'b0);
    chk("rst in_isLast", in_isLast, 1'b0);
    chk("rst out_isReady", out_isReady, 1'b0);
    chk("rst out_isLast", out_isLast, 1'b0);
    chk("rst err_badSlot", err_badSlot, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      case (tbl[i].op)
        OP_WRITE: writeSeed(tbl[i].slot, tbl[i].d0, tbl[i].d1);
        OP_ZERO: begin
          issue(tbl[i].slot, OP_ZERO);
          chk("zero busy", cmd_canReceive, 1'b0);
          @(posedge clk); #1;
          chk("zero done", cmd_canReceive, 1'b1);
        end
        default: readCheck(tbl[i].slot, tbl[i].op, tbl[i].toggle, tbl[i].d0, tbl[i].d1);
      endcase
    end

    // Out-of-range slots: one-cycle error, no beats, no storage change
    issue(3'd5, OP_READ);
    chk("bad slot err", err_badSlot, 1'b1);
    chk("bad slot no out", out_isReady, 1'b0);
    chk("bad slot idle", cmd_canReceive, 1'b1);
    @(posedge clk); #1;
    chk("bad slot err pulse", err_badSlot, 1'b0);
    issue(3'd6, OP_ZERO);
    chk("bad zero err", err_badSlot, 1'b1);
    @(posedge clk); #1;
    issue(3'd7, OP_WRITE);
    chk("bad write no in", in_canReceive, 1'b0);
    @(posedge clk); #1;
    readCheck(3'd4, OP_READ, 1'b0, 64'h55555555_55555555, 64'h66666666_66666666);
    readCheck(3'd1, OP_READ, 1'b0, 64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210);

    // Reset after the first write beat: word0 new, word1 old
    issue(3'd3, OP_WRITE);
    inW = 64'hCCCCCCCC_CCCCCCCC;
    in_isReady = 1'b1;
    @(posedge clk); #1;
    in_isReady = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid rst cmd_canReceive", cmd_canReceive, 1'b1);
    chk("mid rst in_canReceive", in_canReceive, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    readCheck(3'd3, OP_READ, 1'b0, 64'hCCCCCCCC_CCCCCCCC, 64'h44444444_44444444);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
